// File: rtl/urv_dbg_mbx_host.sv
// Host-side bridge to the uRV debug mailbox: queues host words, strobes them into the core
// mailbox one at a time and captures core replies. Optional ack timeout: URV_DBG_MBX_TIMEOUT_EN.
module urv_dbg_mbx_host #(
  parameter int g_fifo_depth     = 4,
  parameter int g_timeout_cycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        host_tx_valid_i,
  input  logic [31:0] host_tx_data_i,
  output logic        host_tx_ready_o,
  output logic        host_rx_valid_o,
  output logic [31:0] host_rx_data_o,
  input  logic        host_rx_ready_i,
  input  logic [31:0] dbg_mbx_data_i,
  output logic [31:0] dbg_mbx_data_o,
  output logic        dbg_mbx_write_o,
  output logic        busy_o,
  output logic        rx_overflow_o,
  output logic        timeout_o,
  input  logic        status_clr_i
);

  localparam int c_aw = $clog2(g_fifo_depth);
  localparam logic [c_aw:0] c_full = g_fifo_depth[c_aw:0];

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WAIT_ACK} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_mem [g_fifo_depth];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0] r_count;
  logic [31:0]   r_shadow;
  logic [31:0]   r_last_wr;
  logic [31:0]   r_rx_data;
  logic          r_rx_valid;
  logic          r_overflow;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_capture;
  logic          w_rx_pop;
  logic          w_tmo_hit;
  logic [31:0]   w_head;

  assign w_full   = (r_count == c_full);
  assign w_pop    = (r_state == ST_WRITE);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_push   = host_tx_valid_i & host_tx_ready_o;
  assign w_rx_pop = r_rx_valid & host_rx_ready_i;

  // The shadow takes our own word on the strobe edge, so the readback of that word is not
  // mistaken for a core write; a core write that wins the same edge still differs and is seen.
  assign w_capture = (dbg_mbx_data_i != r_shadow);

  // Ready is held low while in reset; a full FIFO can still accept while its head is popped.
  assign host_tx_ready_o = rst_n_i & (~w_full | w_pop);
  assign host_rx_valid_o = r_rx_valid;
  assign host_rx_data_o  = r_rx_data;
  assign dbg_mbx_write_o = w_pop;
  assign dbg_mbx_data_o  = w_pop ? w_head : r_last_wr;
  assign busy_o          = (r_state != ST_IDLE) | (r_count != '0);
  assign rx_overflow_o   = r_overflow;

`ifdef URV_DBG_MBX_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_timeout;

  assign w_tmo_hit = (r_state == ST_WAIT_ACK) && ((r_tmo_cnt + 16'd1) == 16'(g_timeout_cycles));
  assign timeout_o = r_timeout;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == ST_WRITE)
        r_tmo_cnt <= '0;
      else if (r_state == ST_WAIT_ACK)
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      // A reply arriving in the last allowed cycle is an ack, not a timeout.
      if (w_tmo_hit && !w_capture)
        r_timeout <= 1'b1;
      else if (status_clr_i)
        r_timeout <= 1'b0;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Leaving IDLE on the push itself gives a strobe in the cycle right after the push.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:     if ((r_count != '0) || w_push) w_state_nxt = ST_WRITE;
      ST_WRITE:    w_state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: if (w_capture || w_tmo_hit) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_push)
      r_mem[r_wr_ptr] <= host_tx_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_shadow   <= '0;
      r_last_wr  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_shadow  <= w_head;
        r_last_wr <= w_head;
      end else if (w_capture) begin
        r_shadow <= dbg_mbx_data_i;
      end
      // An unconsumed reply is kept; the newer word is dropped and flagged.
      if (w_capture && (!r_rx_valid || w_rx_pop)) begin
        r_rx_data  <= dbg_mbx_data_i;
        r_rx_valid <= 1'b1;
      end else if (w_rx_pop) begin
        r_rx_valid <= 1'b0;
      end
      if (w_capture && r_rx_valid && !w_rx_pop)
        r_overflow <= 1'b1;
      else if (status_clr_i)
        r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_urv_dbg_mbx_host.sv
// Scoreboard bench for urv_dbg_mbx_host with a simple core mailbox model (core write wins).
// Timeout scenario is exercised when URV_DBG_MBX_TIMEOUT_EN is defined.
module tb_urv_dbg_mbx_host;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic        txValid;
  logic [31:0] txData;
  logic        txReady;
  logic        rxValid;
  logic [31:0] rxData;
  logic        rxReady;
  logic [31:0] coreMbx;
  logic [31:0] dbgDataOut;
  logic        dbgWrite;
  logic        busy;
  logic        ovf;
  logic        tmo;
  logic        statusClr;

  logic        coreWe;
  logic [31:0] coreVal;

  int totalChecks = 0;
  int badChecks   = 0;
  int strobeCount = 0;
  logic [31:0] expStrobe[$];
  logic [31:0] expRx[$];

  always #5 clk = ~clk;

  urv_dbg_mbx_host #(
    .g_fifo_depth    (DEPTH),
    .g_timeout_cycles(TMO)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rstN),
    .host_tx_valid_i(txValid),
    .host_tx_data_i (txData),
    .host_tx_ready_o(txReady),
    .host_rx_valid_o(rxValid),
    .host_rx_data_o (rxData),
    .host_rx_ready_i(rxReady),
    .dbg_mbx_data_i (coreMbx),
    .dbg_mbx_data_o (dbgDataOut),
    .dbg_mbx_write_o(dbgWrite),
    .busy_o         (busy),
    .rx_overflow_o  (ovf),
    .timeout_o      (tmo),
    .status_clr_i   (statusClr)
  );

  // Core mailbox register: a core CSR write beats the debug load on the same edge.
  always @(posedge clk or negedge rstN) begin
    if (!rstN)
      coreMbx <= '0;
    else if (coreWe)
      coreMbx <= coreVal;
    else if (dbgWrite)
      coreMbx <= dbgDataOut;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: strobes and host rx pops are matched against queued expectations.
  always @(negedge clk) begin
    if (rstN) begin
      if (dbgWrite) begin
        strobeCount++;
        checkOutput("strobe_pending", (expStrobe.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (expStrobe.size() != 0)
          checkOutput("strobe_data", dbgDataOut, expStrobe.pop_front());
      end
      if (rxValid && rxReady) begin
        checkOutput("rx_pending", (expRx.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (expRx.size() != 0)
          checkOutput("rx_data", rxData, expRx.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one host word; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [31:0] data);
    bit done;
    done    = 1'b0;
    txValid = 1'b1;
    txData  = data;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (txReady) begin
        expStrobe.push_back(data);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    txValid = 1'b0;
    if (!done)
      checkOutput("push_accept", 32'd0, 32'd1);
  endtask

  // Returns #1 after the edge that loads the core mailbox, i.e. in the capture cycle.
  task automatic coreWrite(input logic [31:0] val);
    coreWe  = 1'b1;
    coreVal = val;
    step(1);
    coreWe  = 1'b0;
  endtask

  task automatic drainRx();
    for (int i = 0; i < 20 && !rxValid; i++)
      step(1);
    checkOutput("rx_avail", 32'(rxValid), 32'd1);
    if (rxValid) begin
      rxReady = 1'b1;
      step(1);
      rxReady = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstN      = 1'b0;
    txValid   = 1'b0;
    txData    = '0;
    rxReady   = 1'b0;
    statusClr = 1'b0;
    coreWe    = 1'b0;
    coreVal   = '0;
    step(2);
    checkOutput("rst_ready", 32'(txReady), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_write", 32'(dbgWrite), 32'd0);
    checkOutput("rst_rxvalid", 32'(rxValid), 32'd0);
    checkOutput("rst_rxdata", rxData, 32'd0);
    checkOutput("rst_mbxdata", dbgDataOut, 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_tmo", 32'(tmo), 32'd0);
    rstN = 1'b1;
    step(1);
    checkOutput("rel_ready", 32'(txReady), 32'd1);

    // Single word round trip
    applyStimulus(32'h1234_5678);
    checkOutput("strobe_next", 32'(dbgWrite), 32'd1);
    checkOutput("strobe_word", dbgDataOut, 32'h1234_5678);
    step(3);
    checkOutput("busy_wait", 32'(busy), 32'd1);
    checkOutput("data_hold", dbgDataOut, 32'h1234_5678);
    coreWrite(32'h0000_0001);
    expRx.push_back(32'h0000_0001);
    step(1);
    checkOutput("ack_rxvalid", 32'(rxValid), 32'd1);
    checkOutput("ack_rxdata", rxData, 32'h0000_0001);
    checkOutput("ack_busy", 32'(busy), 32'd0);
    drainRx();

    // Back-pressure: one in flight plus a full FIFO
    strobeCount = 0;
    for (int i = 0; i < 5; i++)
      applyStimulus(32'hA000_0000 + 32'(i));
    txValid = 1'b1;
    txData  = 32'hBAD0_BAD0;
    step(4);
    checkOutput("full_ready", 32'(txReady), 32'd0);
    checkOutput("one_strobe", 32'(strobeCount), 32'd1);
    txValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      coreWrite(32'hC0DE_0000 + 32'(i));
      expRx.push_back(32'hC0DE_0000 + 32'(i));
      step(3);
      drainRx();
    end
    checkOutput("all_strobes", 32'(strobeCount), 32'd5);
    checkOutput("drained_busy", 32'(busy), 32'd0);

    // Overflow and sticky clear
    coreWrite(32'h0000_000A);
    coreWrite(32'h0000_000B);
    expRx.push_back(32'h0000_000A);
    step(2);
    checkOutput("ovf_data", rxData, 32'h0000_000A);
    checkOutput("ovf_set", 32'(ovf), 32'd1);
    statusClr = 1'b1;
    step(1);
    statusClr = 1'b0;
    checkOutput("ovf_clr", 32'(ovf), 32'd0);
    drainRx();

    // Set beats clear in the same cycle
    coreWrite(32'h0000_000C);
    expRx.push_back(32'h0000_000C);
    step(2);
    coreWrite(32'h0000_000D);
    statusClr = 1'b1;
    step(1);
    statusClr = 1'b0;
    checkOutput("setwins_ovf", 32'(ovf), 32'd1);
    checkOutput("setwins_data", rxData, 32'h0000_000C);
    statusClr = 1'b1;
    step(1);
    statusClr = 1'b0;
    checkOutput("ovf_clr2", 32'(ovf), 32'd0);

    // Capture together with a pop keeps rx valid and loads the new word
    coreWrite(32'h0000_000E);
    expRx.push_back(32'h0000_000E);
    rxReady = 1'b1;
    step(1);
    rxReady = 1'b0;
    checkOutput("cappop_valid", 32'(rxValid), 32'd1);
    checkOutput("cappop_data", rxData, 32'h0000_000E);
    checkOutput("cappop_ovf", 32'(ovf), 32'd0);
    drainRx();

    // Core write on the same edge as our strobe
    applyStimulus(32'h0000_0099);
    coreWrite(32'h0000_0055);
    expRx.push_back(32'h0000_0055);
    step(1);
    checkOutput("race_rxdata", rxData, 32'h0000_0055);
    checkOutput("race_busy", 32'(busy), 32'd0);
    checkOutput("race_hold", dbgDataOut, 32'h0000_0099);
    drainRx();

`ifdef URV_DBG_MBX_TIMEOUT_EN
    applyStimulus(32'h0000_0777);
    step(8);
    checkOutput("tmo_pre_busy", 32'(busy), 32'd1);
    checkOutput("tmo_pre_flag", 32'(tmo), 32'd0);
    step(1);
    checkOutput("tmo_flag", 32'(tmo), 32'd1);
    checkOutput("tmo_idle", 32'(busy), 32'd0);
    applyStimulus(32'h0000_0888);
    checkOutput("tmo_next_strobe", 32'(dbgWrite), 32'd1);
    coreWrite(32'h0000_4242);
    expRx.push_back(32'h0000_4242);
    step(1);
    checkOutput("tmo_ack_busy", 32'(busy), 32'd0);
    drainRx();
    statusClr = 1'b1;
    step(1);
    statusClr = 1'b0;
    checkOutput("tmo_clr", 32'(tmo), 32'd0);
`else
    applyStimulus(32'h0000_0777);
    step(30);
    checkOutput("notmo_busy", 32'(busy), 32'd1);
    checkOutput("notmo_flag", 32'(tmo), 32'd0);
    coreWrite(32'h0000_4242);
    expRx.push_back(32'h0000_4242);
    step(1);
    checkOutput("notmo_ack_busy", 32'(busy), 32'd0);
    drainRx();
`endif

    // Reset while waiting for an ack with three words queued
    for (int i = 0; i < 4; i++)
      applyStimulus(32'h5000_0000 + 32'(i));
    step(2);
    checkOutput("prerst_busy", 32'(busy), 32'd1);
    rstN = 1'b0;
    step(2);
    expStrobe.delete();
    checkOutput("inrst_busy", 32'(busy), 32'd0);
    checkOutput("inrst_write", 32'(dbgWrite), 32'd0);
    rstN = 1'b1;
    strobeCount = 0;
    step(6);
    checkOutput("postrst_strobes", 32'(strobeCount), 32'd0);
    checkOutput("postrst_busy", 32'(busy), 32'd0);
    checkOutput("postrst_ready", 32'(txReady), 32'd1);
    checkOutput("postrst_rxvalid", 32'(rxValid), 32'd0);

    checkOutput("strobe_q_empty", 32'(expStrobe.size()), 32'd0);
    checkOutput("rx_q_empty", 32'(expRx.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
